// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the 5-stage ARM pipeline,
// with a data-memory wait FSM (timeout to a sticky error) and saturating counters.
module hazard_unit #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             CntClr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;
  state_t           state_q;
  logic [TO_W-1:0]  wcnt_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             memstall, ldrstall, pcpend;
  // R15 reads the PC, never a forwarded result
  assign ForwardAE = (RA1E == 4'd15) ? 2'b00 :
                     (RegWriteM && WA3M == RA1E) ? 2'b10 :
                     (RegWriteW && WA3W == RA1E) ? 2'b01 : 2'b00;
  assign ForwardBE = (RA2E == 4'd15) ? 2'b00 :
                     (RegWriteM && WA3M == RA2E) ? 2'b10 :
                     (RegWriteW && WA3W == RA2E) ? 2'b01 : 2'b00;
  assign memstall = MemReqM & ~MemReadyM & (state_q != S_ERR);
  assign ldrstall = MemtoRegE & (WA3E == RA1D | WA3E == RA2D);
  assign pcpend   = PCSrcD | PCSrcE | PCSrcM;
  assign StallF   = ldrstall | pcpend | memstall;
  assign StallD   = ldrstall | memstall;
  assign StallE   = memstall;
  assign StallM   = memstall;
  assign FlushW   = memstall;
  // frozen stages must keep their contents, so flushes wait for the stall to end
  assign FlushD   = (pcpend | PCSrcW | BranchTakenE) & ~memstall;
  assign FlushE   = (ldrstall | BranchTakenE) & ~memstall;
  assign MemErr   = (state_q == S_ERR);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (memstall) begin
          state_q <= S_WAIT;
          wcnt_q  <= TO_W'(1);
        end
        S_WAIT: if (MemReadyM || !MemReqM) begin
          state_q <= S_IDLE;
          wcnt_q  <= '0;
        end else if (wcnt_q == TO_W'(MEM_TIMEOUT)) begin
          state_q <= S_ERR;
        end else begin
          wcnt_q  <= wcnt_q + TO_W'(1);
        end
        S_ERR: state_q <= S_ERR;
        default: begin
          state_q <= S_IDLE;
          wcnt_q  <= '0;
        end
      endcase
    end
  end
  always_comb begin
    stall_cnt_d = CntClr ? '0 : (StallF && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = CntClr ? '0 : (FlushE && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed vectors with hand-computed expectations for hazard_unit
// (small counters and a short memory timeout so saturation and timeout are reachable).
module tb_hazard_unit;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic BranchTakenE, MemReqM, MemReadyM, CntClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCycles, FlushCycles;
  int n_vec = 0;
  int n_err = 0;
  hazard_unit #(.CNT_W(CNT_W), .TO_W(8), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .CntClr(CntClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // control bits packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {9'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {9'd0, exp});
  endtask
  task automatic chk_cnt(input string tag, input int s, input int f);
    chk({tag, "_stall"}, {12'd0, StallCycles}, 16'(s));
    chk({tag, "_flush"}, {12'd0, FlushCycles}, 16'(f));
  endtask
  task automatic zero_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
    {BranchTakenE, MemReqM, MemReadyM, CntClr} = '0;
  endtask
  task automatic run_timeout(input string tag);
    MemReqM = 1'b1;
    MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_ctl({tag, "_stall"}, 7'b1111001);
      chk({tag, "_noerr"}, {15'd0, MemErr}, 16'd0);
      tick();
    end
    chk_ctl({tag, "_released"}, 7'b0000000);
    chk({tag, "_err"}, {15'd0, MemErr}, 16'd1);
  endtask
  initial begin
    reset = 1'b0;
    zero_inputs();
    #2;
    chk_ctl("reset_ctl", 7'b0000000);
    chk("reset_fwd", {12'd0, ForwardAE, ForwardBE}, 16'd0);
    chk("reset_memerr", {15'd0, MemErr}, 16'd0);
    chk_cnt("reset", 0, 0);
    #10 reset = 1'b1;
    tick();
    // forwarding priority and R15 exclusion
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3; RA2E = 4'd15;
    #1;
    chk("fwdA_M", {14'd0, ForwardAE}, 16'd2);
    chk("fwdB_r15", {14'd0, ForwardBE}, 16'd0);
    RegWriteM = 1'b0;
    #1;
    chk("fwdA_W", {14'd0, ForwardAE}, 16'd1);
    RegWriteM = 1'b1; WA3M = 4'd15; RA1E = 4'd15; RA2E = 4'd3;
    #1;
    chk("fwdA_r15", {14'd0, ForwardAE}, 16'd0);
    chk("fwdB_W", {14'd0, ForwardBE}, 16'd1);
    zero_inputs();
    // load-use stall
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    chk_ctl("ldr", 7'b1100010);
    tick();
    MemtoRegE = 1'b0;
    chk_ctl("ldr_done", 7'b0000000);
    chk_cnt("ldr", 1, 1);
    zero_inputs();
    // branch and PC-write chain
    BranchTakenE = 1'b1; PCSrcE = 1'b1;
    chk_ctl("br_E", 7'b1000110);
    tick();
    BranchTakenE = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b1;
    chk_ctl("br_M", 7'b1000100);
    tick();
    PCSrcM = 1'b0; PCSrcW = 1'b1;
    chk_ctl("br_W", 7'b0000100);
    tick();
    PCSrcW = 1'b0;
    chk_cnt("br", 3, 2);
    // memory wait, ready on the fourth cycle
    MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("mem_wait", 7'b1111001);
      tick();
    end
    MemReadyM = 1'b1;
    chk_ctl("mem_ready", 7'b0000000);
    tick();
    zero_inputs();
    chk("mem_memerr", {15'd0, MemErr}, 16'd0);
    // memory stall holds off a branch flush
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_ctl("memflush_hold", 7'b1111001);
      tick();
    end
    MemReadyM = 1'b1;
    chk_ctl("memflush_release", 7'b0000110);
    tick();
    zero_inputs();
    chk_cnt("memflush", 8, 3);
    CntClr = 1'b1;
    tick();
    CntClr = 1'b0;
    chk_cnt("clr", 0, 0);
    // saturation of the 4-bit stall counter
    PCSrcD = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    PCSrcD = 1'b0;
    chk_cnt("sat", 15, 0);
    CntClr = 1'b1; PCSrcD = 1'b1;
    tick();
    CntClr = 1'b0; PCSrcD = 1'b0;
    chk_cnt("clr_prio", 0, 0);
    // timeout into the sticky error state
    run_timeout("to1");
    chk_cnt("to1", 5, 0);
    tick();
    tick();
    MemReqM = 1'b0;
    tick();
    chk("to1_sticky", {15'd0, MemErr}, 16'd1);
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    chk_ctl("err_noflushblock", 7'b0000110);
    BranchTakenE = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_rst_memerr", {15'd0, MemErr}, 16'd0);
    chk_cnt("async_rst", 0, 0);
    chk_ctl("rst_req_stall", 7'b1111001);
    MemReqM = 1'b0;
    #1 reset = 1'b1;
    // reset asserted mid-WAIT
    tick();
    MemReqM = 1'b1;
    tick();
    tick();
    #1 reset = 1'b0;
    chk_ctl("midwait_rst_req", 7'b1111001);
    MemReqM = 1'b0;
    chk_ctl("midwait_rst_drop", 7'b0000000);
    #1 reset = 1'b1;
    tick();
    run_timeout("to2");
    zero_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer end of the controller's hazard interface in the 5-stage ARM pipeline.
- Takes controller status (PCSrcD/E/M/W, BranchTakenE, MemtoRegE, RegWriteM/W) and the datapath register addresses.
- Returns the stall, flush and forwarding controls, including the FlushE that the controller's D/E register consumes.
- Adds a data-memory wait FSM with timeout, and saturating performance counters.

Parameters:
CNT_W, 16, width of the performance counters
TO_W, 8, width of the memory-wait counter
MEM_TIMEOUT, 255, wait cycles before the error state; legal range 1..2^TO_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low; 0 resets all state
RA1D  input  4  Rn address in Decode
RA2D  input  4  Rm/Rd address in Decode
RA1E  input  4  Rn address in Execute
RA2E  input  4  Rm/Rd address in Execute
WA3E  input  4  destination address in Execute
WA3M  input  4  destination address in Memory
WA3W  input  4  destination address in Writeback
RegWriteM  input  1  conditioned register write in Memory
RegWriteW  input  1  register write in Writeback
MemtoRegE  input  1  load in Execute
PCSrcD  input  1  PC write in Decode
PCSrcE  input  1  PC write in Execute
PCSrcM  input  1  PC write in Memory
PCSrcW  input  1  PC write in Writeback
BranchTakenE  input  1  branch resolved taken in Execute
MemReqM  input  1  load/store active in Memory
MemReadyM  input  1  data memory completes the access this cycle
CntClr  input  1  synchronous clear of the performance counters
ForwardAE  output  2  SrcA mux select: 00 = reg file, 01 = ResultW, 10 = ALUOutM
ForwardBE  output  2  SrcB mux select, same encoding as ForwardAE
StallF  output  1  hold PC
StallD  output  1  hold F/D register
StallE  output  1  hold D/E register
StallM  output  1  hold E/M register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register
FlushW  output  1  clear M/W register (inject bubble)
MemErr  output  1  sticky memory timeout flag
StallCycles  output  CNT_W  count of cycles with StallF=1
FlushCycles  output  CNT_W  count of cycles with FlushE=1

Behaviour:
- Reset:
  - FSM=IDLE, wait counter=0, MemErr=0, StallCycles=0, FlushCycles=0.
  - All other outputs are combinational; each is 0 when all inputs are 0.
- Forwarding (combinational), applied to ForwardAE using RA1E and to ForwardBE using RA2E:
  - 10 if RegWriteM and WA3M==RAxE.
  - Else 01 if RegWriteW and WA3W==RAxE.
  - Else 00.
  - M has priority over W. RAxE==4'd15 always yields 00.
- Definitions:
  - memstall = MemReqM & ~MemReadyM & (state!=ERR).
  - ldrstall = MemtoRegE & (WA3E==RA1D | WA3E==RA2D).
  - pcpend = PCSrcD | PCSrcE | PCSrcM.
- Stall and flush outputs:
  - StallF = ldrstall | pcpend | memstall.
  - StallD = ldrstall | memstall.
  - StallE = StallM = FlushW = memstall.
  - FlushD = (pcpend | PCSrcW | BranchTakenE) & ~memstall.
  - FlushE = (ldrstall | BranchTakenE) & ~memstall.
  - memstall suppresses flushes so that the frozen stages keep their contents. Held flush causes reapply once memstall drops.
- FSM states IDLE, WAIT, ERR:
  - IDLE -> WAIT when memstall=1; wait counter loads 1.
  - WAIT -> IDLE when MemReadyM=1 or MemReqM=0; counter cleared.
  - WAIT, otherwise: counter increments. On the edge where counter==MEM_TIMEOUT, go to ERR.
  - ERR: MemErr=1 and memstall forced 0, so the pipeline proceeds. Exit only by reset.
- Latency and timeout:
  - Stall release is combinational: the cycle MemReadyM=1, all stalls drop.
  - Worst-case stall is MEM_TIMEOUT+1 cycles.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at all-ones; no wrap.
  - CntClr has priority over increment; the counter reads 0 next cycle.
- Reset asserted mid-WAIT: state returns to IDLE immediately (asynchronous). Stalls drop as soon as MemReqM deasserts or reset is released with no request.

Test Plan:
- RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3, RA2E=15 -> ForwardAE=10, ForwardBE=00. Then drop RegWriteM -> ForwardAE=01.
- MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0. After one cycle with MemtoRegE=0 -> all 0. StallCycles=1, FlushCycles=1.
- BranchTakenE=1 with PCSrcE=1 -> FlushD=FlushE=1, StallF=1. Then PCSrcM=1, then PCSrcW=1 -> FlushD stays 1 each cycle.
- MemReqM=1 for 4 cycles, MemReadyM=1 in the 4th -> StallF/D/E/M and FlushW=1 for 3 cycles, 0 in the 4th. FSM returns to IDLE, MemErr=0.
- MEM_TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> stall for 5 cycles, then MemErr=1 and stalls 0. MemErr stays 1 until reset=0.
- Memory stall concurrent with BranchTakenE=1 -> FlushD=FlushE=0 while stalled; both 1 the cycle MemReadyM=1. Assert CntClr -> counters read 0 next cycle.
